// File: rtl/timing_fsm.sv
// rtl/timing_fsm.sv - per-bank DRAM protocol state and timing tracker
module timing_fsm #(
    parameter int BGWIDTH = 2,
    parameter int BAWIDTH = 2,
    parameter int BL      = 8,
    parameter int T_RCD   = 15,
    parameter int T_RP    = 15,
    parameter int T_RFC   = 34,
    parameter int T_MRR   = 2,
    parameter int T_MRW   = 10
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [(BGWIDTH > 0 ? BGWIDTH : 1)-1:0] bg,
    input  logic [BAWIDTH-1:0]                    ba,
    input  logic                                  ACT,
    input  logic                                  BST,
    input  logic                                  CFG,
    input  logic                                  CKEH,
    input  logic                                  CKEL,
    input  logic                                  DPD,
    input  logic                                  DPDX,
    input  logic                                  MRR,
    input  logic                                  MRW,
    input  logic                                  PD,
    input  logic                                  PDX,
    input  logic                                  PR,
    input  logic                                  PRA,
    input  logic                                  RD,
    input  logic                                  RDA,
    input  logic                                  REF,
    input  logic                                  SRF,
    input  logic                                  WR,
    input  logic                                  WRA,
    output logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0][4:0] BankFSM
);
    localparam int BGW  = (BGWIDTH > 0) ? BGWIDTH : 1;
    localparam int BPG  = 2**BAWIDTH;
    localparam int NB   = (2**BGWIDTH) * BPG;
    localparam int TBUR = BL / 2;
    localparam int M1   = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int M2   = (T_RFC > T_MRW) ? T_RFC : T_MRW;
    localparam int M3   = (T_MRR > TBUR) ? T_MRR : TBUR;
    localparam int M12  = (M1 > M2) ? M1 : M2;
    localparam int TMAX = (M12 > M3) ? M12 : M3;
    localparam int CW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] LD_RCD = CW'(T_RCD - 1);
    localparam logic [CW-1:0] LD_RP  = CW'(T_RP - 1);
    localparam logic [CW-1:0] LD_RFC = CW'(T_RFC - 1);
    localparam logic [CW-1:0] LD_MRR = CW'(T_MRR - 1);
    localparam logic [CW-1:0] LD_MRW = CW'(T_MRW - 1);
    localparam logic [CW-1:0] LD_BUR = CW'(TBUR - 1);

    typedef enum logic [4:0] {
        S_IDLE         = 5'd0,
        S_ACTIVATING   = 5'd1,
        S_BANK_ACTIVE  = 5'd2,
        S_READING      = 5'd3,
        S_READING_APR  = 5'd4,
        S_WRITING      = 5'd5,
        S_WRITING_APR  = 5'd6,
        S_PRECHARGING  = 5'd7,
        S_REFRESHING   = 5'd8,
        S_ACTIVE_PD    = 5'd9,
        S_IDLE_PD      = 5'd10,
        S_SELF_REFRESH = 5'd11,
        S_DEEP_PD      = 5'd12,
        S_MR_READING   = 5'd13,
        S_MR_WRITING   = 5'd14
    } bank_state_e;

    bank_state_e   state_q [NB];
    bank_state_e   state_d [NB];
    logic [CW-1:0] cnt_q   [NB];
    logic [CW-1:0] cnt_d   [NB];
    logic          sel     [NB];

    logic unused_cfg;
    assign unused_cfg = CFG;

    always_comb begin
        for (int b = 0; b < NB; b++) begin
            sel[b] = (ba == BAWIDTH'(b % BPG)) &&
                     ((BGWIDTH == 0) || (bg == BGW'(b / BPG)));
        end
    end

    // Within each state, commands are tested in global priority order, so the
    // first legal match is the highest-priority legal command.
    always_comb begin
        for (int b = 0; b < NB; b++) begin
            state_d[b] = state_q[b];
            cnt_d[b]   = cnt_q[b] - 1'b1;
            case (state_q[b])
                S_IDLE: begin
                    cnt_d[b] = cnt_q[b];
                    if (REF) begin
                        state_d[b] = S_REFRESHING;   cnt_d[b] = LD_RFC;
                    end else if (ACT && sel[b]) begin
                        state_d[b] = S_ACTIVATING;   cnt_d[b] = LD_RCD;
                    end else if (MRR && sel[b]) begin
                        state_d[b] = S_MR_READING;   cnt_d[b] = LD_MRR;
                    end else if (MRW && sel[b]) begin
                        state_d[b] = S_MR_WRITING;   cnt_d[b] = LD_MRW;
                    end else if (SRF) begin
                        state_d[b] = S_SELF_REFRESH;
                    end else if (DPD) begin
                        state_d[b] = S_DEEP_PD;
                    end else if (PD || CKEL) begin
                        state_d[b] = S_IDLE_PD;
                    end
                end
                S_ACTIVATING: if (cnt_q[b] == '0) state_d[b] = S_BANK_ACTIVE;
                S_BANK_ACTIVE: begin
                    cnt_d[b] = cnt_q[b];
                    if (PRA || (PR && sel[b])) begin
                        state_d[b] = S_PRECHARGING;  cnt_d[b] = LD_RP;
                    end else if (ACT && sel[b]) begin
                        state_d[b] = S_ACTIVATING;   cnt_d[b] = LD_RCD;
                    end else if (RDA && sel[b]) begin
                        state_d[b] = S_READING_APR;  cnt_d[b] = LD_BUR;
                    end else if (RD && sel[b]) begin
                        state_d[b] = S_READING;      cnt_d[b] = LD_BUR;
                    end else if (WRA && sel[b]) begin
                        state_d[b] = S_WRITING_APR;  cnt_d[b] = LD_BUR;
                    end else if (WR && sel[b]) begin
                        state_d[b] = S_WRITING;      cnt_d[b] = LD_BUR;
                    end else if (PD || CKEL) begin
                        state_d[b] = S_ACTIVE_PD;
                    end
                end
                S_READING, S_WRITING: begin
                    if (RD && sel[b]) begin
                        state_d[b] = S_READING;      cnt_d[b] = LD_BUR;
                    end else if (WR && sel[b]) begin
                        state_d[b] = S_WRITING;      cnt_d[b] = LD_BUR;
                    end else if (BST && sel[b]) begin
                        state_d[b] = S_BANK_ACTIVE;  cnt_d[b] = cnt_q[b];
                    end else if (cnt_q[b] == '0) begin
                        state_d[b] = S_BANK_ACTIVE;
                    end
                end
                S_READING_APR, S_WRITING_APR: begin
                    if (cnt_q[b] == '0) begin
                        state_d[b] = S_PRECHARGING;  cnt_d[b] = LD_RP;
                    end
                end
                S_PRECHARGING, S_REFRESHING, S_MR_READING, S_MR_WRITING:
                    if (cnt_q[b] == '0) state_d[b] = S_IDLE;
                S_ACTIVE_PD: begin
                    cnt_d[b] = cnt_q[b];
                    if (PDX || CKEH) state_d[b] = S_BANK_ACTIVE;
                end
                S_IDLE_PD: begin
                    cnt_d[b] = cnt_q[b];
                    if (PDX || CKEH) state_d[b] = S_IDLE;
                end
                S_SELF_REFRESH: begin
                    cnt_d[b] = cnt_q[b];
                    if (CKEH) state_d[b] = S_IDLE;
                end
                S_DEEP_PD: begin
                    cnt_d[b] = cnt_q[b];
                    if (DPDX) state_d[b] = S_IDLE;
                end
                default: begin
                    state_d[b] = S_IDLE;
                    cnt_d[b]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (reset_n) begin
                state_q[b] <= S_IDLE;
                cnt_q[b]   <= '0;
            end else begin
                state_q[b] <= state_d[b];
                cnt_q[b]   <= cnt_d[b];
            end
        end
    end

    for (genvar g = 0; g < 2**BGWIDTH; g++) begin : g_grp
        for (genvar a = 0; a < BPG; a++) begin : g_bank
            assign BankFSM[g][a] = state_q[g*BPG + a];
        end
    end
endmodule

// File: tb/tb_timing_fsm.sv
// tb/tb_timing_fsm.sv - directed scoreboard bench for timing_fsm
module tb_timing_fsm;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic [1:0] bg = '0;
    logic [1:0] ba = '0;
    logic ACT = 0, BST = 0, CFG = 0, CKEH = 0, CKEL = 0, DPD = 0, DPDX = 0;
    logic MRR = 0, MRW = 0, PD = 0, PDX = 0, PR = 0, PRA = 0, RD = 0;
    logic RDA = 0, REF = 0, SRF = 0, WR = 0, WRA = 0;
    logic [3:0][3:0][4:0] BankFSM;

    timing_fsm dut (
        .clk(clk), .reset_n(reset_n), .bg(bg), .ba(ba),
        .ACT(ACT), .BST(BST), .CFG(CFG), .CKEH(CKEH), .CKEL(CKEL),
        .DPD(DPD), .DPDX(DPDX), .MRR(MRR), .MRW(MRW), .PD(PD), .PDX(PDX),
        .PR(PR), .PRA(PRA), .RD(RD), .RDA(RDA), .REF(REF), .SRF(SRF),
        .WR(WR), .WRA(WRA), .BankFSM(BankFSM)
    );

    always #5 clk = ~clk;

    logic [4:0]  exp_st [16];
    logic [79:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    function automatic logic [79:0] exp_vec();
        logic [79:0] v;
        for (int i = 0; i < 16; i++) v[i*5 +: 5] = exp_st[i];
        return v;
    endfunction

    task automatic set_all(input logic [4:0] v);
        for (int i = 0; i < 16; i++) exp_st[i] = v;
    endtask

    task automatic clr();
        {ACT, BST, CFG, CKEH, CKEL, DPD, DPDX, MRR, MRW} = '0;
        {PD, PDX, PR, PRA, RD, RDA, REF, SRF, WR, WRA} = '0;
    endtask

    // Inputs applied now take effect at the next edge; expected value is queued after it.
    task automatic tick();
        @(posedge clk);
        #1;
        exp_q.push_back(exp_vec());
        clr();
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [79:0] e;
            e = exp_q.pop_front();
            checks++;
            if (BankFSM !== e) begin
                errors++;
                $display("FAIL bankfsm cycle %0d actual %h required %h", cyc, BankFSM, e);
            end
            cyc++;
        end
    end

    localparam int B = 5;

    initial begin
        set_all(5'd0);
        reset_n = 1'b1; tick();
        reset_n = 1'b0; ticks(3);

        bg = 2'd1; ba = 2'd1;
        ACT = 1; exp_st[B] = 5'd1; tick(); ticks(14);
        exp_st[B] = 5'd2; ticks(2);

        WR = 1; exp_st[B] = 5'd5; tick(); ticks(3);
        exp_st[B] = 5'd2; ticks(2);

        RD = 1; exp_st[B] = 5'd3; tick(); tick();
        WR = 1; exp_st[B] = 5'd5; tick(); ticks(2);
        PR = 1; tick();
        BST = 1; exp_st[B] = 5'd2; tick(); ticks(2);

        ACT = 1; exp_st[B] = 5'd1; tick(); ticks(14);
        exp_st[B] = 5'd2; tick();

        RD = 1; exp_st[B] = 5'd3; tick(); ticks(3);
        exp_st[B] = 5'd2; tick();

        bg = 2'd0; ba = 2'd2;
        ACT = 1; exp_st[2] = 5'd1; tick(); ticks(14);
        exp_st[2] = 5'd2; tick();
        PRA = 1; exp_st[2] = 5'd7; exp_st[B] = 5'd7; tick(); ticks(14);
        exp_st[2] = 5'd0; exp_st[B] = 5'd0; tick();

        bg = 2'd1; ba = 2'd1;
        REF = 1; set_all(5'd8); tick();
        ACT = 1; tick(); ticks(32);
        set_all(5'd0); ticks(2);

        ACT = 1; exp_st[B] = 5'd1; tick(); ticks(14);
        exp_st[B] = 5'd2; tick();
        RDA = 1; exp_st[B] = 5'd4; tick(); ticks(3);
        exp_st[B] = 5'd7; ticks(15);
        exp_st[B] = 5'd0; tick();

        MRW = 1; exp_st[B] = 5'd14; tick(); ticks(9);
        exp_st[B] = 5'd0; tick();

        PD = 1; set_all(5'd10); tick(); tick();
        PDX = 1; set_all(5'd0); tick();
        SRF = 1; set_all(5'd11); tick();
        PDX = 1; tick();
        CKEH = 1; set_all(5'd0); tick();
        DPD = 1; set_all(5'd12); tick();
        CKEH = 1; tick();
        DPDX = 1; set_all(5'd0); tick();

        ACT = 1; exp_st[B] = 5'd1; tick(); ticks(3);
        reset_n = 1'b1; exp_st[B] = 5'd0; tick();
        reset_n = 1'b0; ticks(2);

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual running required finished");
        $fatal(1);
    end
endmodule
